// File: rtl/puntuacion_acumulador_if.sv
`default_nettype none
// ============================================================================
// Module   : puntuacion_acumulador_if
// Purpose  : Groups the judging-event inputs and the 13-bit score bus of the
//            score accumulator into one bundle.
// Ports    : inicio, fin, golpe, fallo      - single-cycle game events
//            puntuacionSalida, combo,
//            multiplicador, puntuacionNueva,
//            standBy                        - score bus towards the display
// Modports : master - the accumulator (consumes events, writes the score bus)
//            slave  - the environment (produces events, reads the score bus)
// Revision : 1.0 - initial release
// ============================================================================
interface puntuacion_acumulador_if #(
    parameter int ANCHO_PUNTOS = 13
);
    logic                    inicio;
    logic                    fin;
    logic                    golpe;
    logic                    fallo;
    logic [ANCHO_PUNTOS-1:0] puntuacionSalida;
    logic [7:0]              combo;
    logic [2:0]              multiplicador;
    logic                    puntuacionNueva;
    logic                    standBy;

    modport master (
        input  inicio, fin, golpe, fallo,
        output puntuacionSalida, combo, multiplicador, puntuacionNueva, standBy
    );

    modport slave (
        output inicio, fin, golpe, fallo,
        input  puntuacionSalida, combo, multiplicador, puntuacionNueva, standBy
    );
endinterface
`default_nettype wire

// File: rtl/puntuacion_acumulador.sv
`default_nettype none
// ============================================================================
// Module   : puntuacion_acumulador
// Purpose  : Running game score with combo multiplier. Sequences a game
//            IDLE -> JUGANDO -> FIN and raises standBy once the song ends.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous, active-high
//            bus   - puntuacion_acumulador_if.master (events in, score out)
// Revision : 1.0 - initial release
// ============================================================================
module puntuacion_acumulador #(
    parameter int ANCHO_PUNTOS     = 13,
    parameter int PUNTOS_BASE      = 10,
    parameter int GOLPES_POR_NIVEL = 8,
    parameter int MULT_MAX         = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    puntuacion_acumulador_if.master     bus
);

    localparam int                      ANCHO_SUMA = ANCHO_PUNTOS + 1;
    localparam logic [ANCHO_PUNTOS-1:0] PUNTOS_MAX = '1;
    localparam logic [7:0]              COMBO_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_JUGANDO = 2'd1,
        S_FIN     = 2'd2
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [ANCHO_PUNTOS-1:0] puntos_q, puntos_d;
    logic [7:0]              combo_q,  combo_d;
    logic [2:0]              mult_q,   mult_d;
    logic                    nueva_q,  nueva_d;

    logic [ANCHO_SUMA-1:0]   w_incremento;
    logic [ANCHO_SUMA-1:0]   w_suma;
    logic [ANCHO_PUNTOS-1:0] w_puntos_sat;
    logic [7:0]              w_combo_inc;
    logic                    w_sube_nivel;

    // Score sum carries one guard bit; a set guard bit means overflow.
    assign w_incremento = ANCHO_SUMA'(PUNTOS_BASE) * ANCHO_SUMA'(mult_q);
    assign w_suma       = {1'b0, puntos_q} + w_incremento;
    assign w_puntos_sat = w_suma[ANCHO_SUMA-1] ? PUNTOS_MAX : w_suma[ANCHO_PUNTOS-1:0];

    assign w_combo_inc  = (combo_q == COMBO_MAX) ? COMBO_MAX : combo_q + 8'd1;

    // The multiplier steps up on the hit that completes a level; the new
    // value is only used for the following hit's increment.
    assign w_sube_nivel = ((w_combo_inc % 8'(GOLPES_POR_NIVEL)) == 8'd0) &&
                          (mult_q < 3'(MULT_MAX));

    always_comb begin
        estado_d = estado_q;
        puntos_d = puntos_q;
        combo_d  = combo_q;
        mult_d   = mult_q;
        nueva_d  = 1'b0;

        // inicio starts (or restarts) a game from any state.
        if (bus.inicio) begin
            estado_d = S_JUGANDO;
            puntos_d = '0;
            combo_d  = '0;
            mult_d   = 3'd1;
            nueva_d  = 1'b1;
        end else begin
            case (estado_q)
                S_IDLE: begin
                    estado_d = S_IDLE;
                end
                S_JUGANDO: begin
                    // A miss wins over a simultaneous hit.
                    if (bus.fallo) begin
                        combo_d = '0;
                        mult_d  = 3'd1;
                    end else if (bus.golpe) begin
                        puntos_d = w_puntos_sat;
                        combo_d  = w_combo_inc;
                        nueva_d  = (w_puntos_sat != puntos_q);
                        if (w_sube_nivel) begin
                            mult_d = mult_q + 3'd1;
                        end
                    end
                    // The hit of the final cycle is still scored above.
                    if (bus.fin) begin
                        estado_d = S_FIN;
                    end
                end
                S_FIN: begin
                    estado_d = S_FIN;
                end
                default: begin
                    estado_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= S_IDLE;
            puntos_q <= '0;
            combo_q  <= '0;
            mult_q   <= 3'd1;
            nueva_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            puntos_q <= puntos_d;
            combo_q  <= combo_d;
            mult_q   <= mult_d;
            nueva_q  <= nueva_d;
        end
    end

    assign bus.puntuacionSalida = puntos_q;
    assign bus.combo            = combo_q;
    assign bus.multiplicador    = mult_q;
    assign bus.puntuacionNueva  = nueva_q;
    assign bus.standBy          = (estado_q == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_puntuacion_acumulador.sv
`default_nettype none
// ============================================================================
// Module   : tb_puntuacion_acumulador
// Purpose  : Self-checking bench for puntuacion_acumulador. A game-level
//            model tracks score/combo/multiplier/state and is compared with
//            the DUT every cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_puntuacion_acumulador;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    puntuacion_acumulador_if #(.ANCHO_PUNTOS(13)) bus ();

    puntuacion_acumulador #(
        .ANCHO_PUNTOS     (13),
        .PUNTOS_BASE      (10),
        .GOLPES_POR_NIVEL (8),
        .MULT_MAX         (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Game-level model: plain integers, rules applied per clock.
    // state: 0 idle, 1 playing, 2 finished
    // ------------------------------------------------------------------
    typedef struct {
        int score;
        int combo;
        int mult;
        int state;
        bit nueva;
    } modelo_t;

    function automatic modelo_t modelo_reset();
        modelo_t r;
        r.score = 0; r.combo = 0; r.mult = 1; r.state = 0; r.nueva = 1'b0;
        return r;
    endfunction

    function automatic modelo_t paso(modelo_t m, bit ini, bit f, bit g, bit fa);
        modelo_t n;
        int      s;
        n = m;
        n.nueva = 1'b0;
        if (ini) begin
            n.score = 0; n.combo = 0; n.mult = 1; n.state = 1; n.nueva = 1'b1;
            return n;
        end
        if (m.state == 1) begin
            if (fa) begin
                n.combo = 0;
                n.mult  = 1;
            end else if (g) begin
                s = m.score + 10 * m.mult;
                if (s > 8191) s = 8191;
                n.nueva = (s != m.score);
                n.score = s;
                n.combo = (m.combo < 255) ? m.combo + 1 : 255;
                if ((n.combo % 8) == 0 && m.mult < 4) n.mult = m.mult + 1;
            end
            if (f) n.state = 2;
        end
        return n;
    endfunction

    modelo_t m = modelo_reset();

    always @(posedge clk or posedge reset) begin
        if (reset) m <= modelo_reset();
        else       m <= paso(m, bus.inicio, bus.fin, bus.golpe, bus.fallo);
    end

    task automatic chk(string nombre, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_score", 32'(bus.puntuacionSalida), 32'(m.score));
            chk("model_combo", 32'(bus.combo),            32'(m.combo));
            chk("model_mult",  32'(bus.multiplicador),    32'(m.mult));
            chk("model_nueva", 32'(bus.puntuacionNueva),  32'(m.nueva));
            chk("model_stby",  32'(bus.standBy),          32'(m.state == 2));
        end
    end

    // One event cycle; entered and left at posedge+1.
    task automatic evento(bit ini, bit f, bit g, bit fa);
        bus.inicio = ini; bus.fin = f; bus.golpe = g; bus.fallo = fa;
        @(posedge clk); #1;
        bus.inicio = 1'b0; bus.fin = 1'b0; bus.golpe = 1'b0; bus.fallo = 1'b0;
    endtask

    task automatic espera(int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_score"}, 32'(bus.puntuacionSalida), 32'd0);
        chk({tag, "_combo"}, 32'(bus.combo),            32'd0);
        chk({tag, "_mult"},  32'(bus.multiplicador),    32'd1);
        chk({tag, "_nueva"}, 32'(bus.puntuacionNueva),  32'd0);
        chk({tag, "_stby"},  32'(bus.standBy),          32'd0);
    endtask

    initial begin
        bus.inicio = 1'b0; bus.fin = 1'b0; bus.golpe = 1'b0; bus.fallo = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        chk_reset("rst");

        // Three spaced hits at x1.
        evento(1, 0, 0, 0);
        chk("start_nueva", 32'(bus.puntuacionNueva), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            evento(0, 0, 1, 0);
            chk("hit_score", 32'(bus.puntuacionSalida), 32'(10 * k));
            chk("hit_nueva", 32'(bus.puntuacionNueva),  32'd1);
            espera(1);
            chk("hit_nueva_off", 32'(bus.puntuacionNueva), 32'd0);
        end
        chk("hit_combo", 32'(bus.combo),         32'd3);
        chk("hit_mult",  32'(bus.multiplicador), 32'd1);

        // Multiplier ramp.
        evento(1, 0, 0, 0);
        for (int k = 1; k <= 32; k++) begin
            evento(0, 0, 1, 0);
            if (k == 8)  begin chk("ramp8_score",  32'(bus.puntuacionSalida), 32'd80);  chk("ramp8_mult",  32'(bus.multiplicador), 32'd2); end
            if (k == 9)  begin chk("ramp9_score",  32'(bus.puntuacionSalida), 32'd100); end
            if (k == 16) begin chk("ramp16_score", 32'(bus.puntuacionSalida), 32'd240); chk("ramp16_mult", 32'(bus.multiplicador), 32'd3); end
            if (k == 24) begin chk("ramp24_score", 32'(bus.puntuacionSalida), 32'd480); chk("ramp24_mult", 32'(bus.multiplicador), 32'd4); end
            if (k == 32) begin chk("ramp32_score", 32'(bus.puntuacionSalida), 32'd800); chk("ramp32_mult", 32'(bus.multiplicador), 32'd4); end
        end

        // Miss in the middle of a combo, then hit+miss together.
        evento(1, 0, 0, 0);
        repeat (10) evento(0, 0, 1, 0);
        chk("pre_miss_score", 32'(bus.puntuacionSalida), 32'd120);
        chk("pre_miss_mult",  32'(bus.multiplicador),    32'd2);
        evento(0, 0, 0, 1);
        chk("miss_score", 32'(bus.puntuacionSalida), 32'd120);
        chk("miss_combo", 32'(bus.combo),            32'd0);
        chk("miss_mult",  32'(bus.multiplicador),    32'd1);
        chk("miss_nueva", 32'(bus.puntuacionNueva),  32'd0);
        evento(0, 0, 1, 1);
        chk("both_score", 32'(bus.puntuacionSalida), 32'd120);
        chk("both_combo", 32'(bus.combo),            32'd0);

        // Saturation and combo ceiling.
        evento(1, 0, 0, 0);
        repeat (216) evento(0, 0, 1, 0);
        chk("presat_score", 32'(bus.puntuacionSalida), 32'd8160);
        chk("presat_mult",  32'(bus.multiplicador),    32'd4);
        evento(0, 0, 1, 0);
        chk("sat_score", 32'(bus.puntuacionSalida), 32'd8191);
        chk("sat_nueva", 32'(bus.puntuacionNueva),  32'd1);
        evento(0, 0, 1, 0);
        chk("sat2_score", 32'(bus.puntuacionSalida), 32'd8191);
        chk("sat2_nueva", 32'(bus.puntuacionNueva),  32'd0);
        repeat (40) evento(0, 0, 1, 0);
        chk("combo_sat", 32'(bus.combo),         32'd255);
        chk("mult_sat",  32'(bus.multiplicador), 32'd4);

        // End of song, frozen state, restart.
        evento(0, 1, 0, 0);
        chk("fin_stby", 32'(bus.standBy), 32'd1);
        evento(0, 0, 1, 0);
        chk("fin_frozen_score", 32'(bus.puntuacionSalida), 32'd8191);
        chk("fin_frozen_combo", 32'(bus.combo),            32'd255);
        chk("fin_frozen_nueva", 32'(bus.puntuacionNueva),  32'd0);
        evento(1, 0, 0, 0);
        chk("restart_stby",  32'(bus.standBy),          32'd0);
        chk("restart_score", 32'(bus.puntuacionSalida), 32'd0);
        chk("restart_nueva", 32'(bus.puntuacionNueva),  32'd1);
        chk("restart_mult",  32'(bus.multiplicador),    32'd1);
        evento(0, 0, 1, 0);
        evento(0, 1, 1, 0);
        chk("finhit_score", 32'(bus.puntuacionSalida), 32'd20);
        chk("finhit_stby",  32'(bus.standBy),          32'd1);
        evento(0, 0, 1, 0);
        chk("finhit_frozen", 32'(bus.puntuacionSalida), 32'd20);

        // Asynchronous reset in the middle of a game.
        evento(1, 0, 0, 0);
        repeat (3) evento(0, 0, 1, 0);
        chk("prereset_score", 32'(bus.puntuacionSalida), 32'd30);
        #2 reset = 1'b1;
        #1 chk_reset("async");
        @(posedge clk); #1 reset = 1'b0;
        evento(0, 0, 1, 0);
        chk("idle_hit_score", 32'(bus.puntuacionSalida), 32'd0);
        chk("idle_hit_nueva", 32'(bus.puntuacionNueva),  32'd0);
        evento(0, 1, 0, 1);
        chk("idle_fin_stby", 32'(bus.standBy), 32'd0);
        espera(2);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
